// File: rtl/port_info_pkg.sv
// Shared types for the info-record dispatch slice: the packed record carried
// from info assembly and the per-port credit counter type.
package port_info_pkg;

    localparam int PORT_W    = 4;
    localparam int NUM_PORTS = 2 ** PORT_W;
    // Wide enough for any credit budget from 1 to 15.
    localparam int CREDIT_W  = 4;

    typedef struct packed {
        logic [PORT_W-1:0] port_num;
    } info_t;

    typedef logic [CREDIT_W-1:0] credit_t;

endpackage

// File: rtl/port_info_fifo.sv
// Small synchronous FIFO of info_t records with an explicit occupancy count
// so that full and empty are distinguished without an extra pointer bit.
module port_info_fifo
    import port_info_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             push,
    input  info_t            push_info,
    input  logic             pop,
    output info_t            head_info,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    info_t            mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against the current occupancy.
    always_comb begin
        push_ok_s = push && (count_r != DEPTH_C);
        pop_ok_s  = pop && (count_r != CNT_W'(0));
    end

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_info;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_info = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/port_info_dispatch.sv
// Buffers info records and issues each in order to its destination port only
// while that port holds a credit; a starved head blocks everything behind it.
module port_info_dispatch
    import port_info_pkg::*;
#(
    parameter  int DEPTH   = 4,
    parameter  int CREDITS = 2,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  info_t                in_info,
    output logic                 out_valid,
    input  logic                 out_ready,
    output info_t                out_info,
    input  logic [NUM_PORTS-1:0] credit_ret,
    output logic [NUM_PORTS-1:0] credit_avail,
    output logic [CNT_W-1:0]     fifo_count,
    output logic                 ovf_err
);

    localparam credit_t          CREDIT_MAX = credit_t'(CREDITS);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);

    credit_t          credit_r     [NUM_PORTS];
    credit_t          credit_nxt_s [NUM_PORTS];
    logic             ovf_r;
    logic             ovf_hit_s;
    logic             rdy_en_r;
    info_t            head_s;
    logic [CNT_W-1:0] count_s;
    logic             nonempty_s;
    logic             push_s;
    logic             pop_s;

    port_info_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .res       (res),
        .push      (push_s),
        .push_info (in_info),
        .pop       (pop_s),
        .head_info (head_s),
        .count     (count_s)
    );

    // Handshake and head presentation, all derived from registered state.
    always_comb begin
        nonempty_s = (count_s != CNT_W'(0));
        in_ready   = rdy_en_r && (count_s != DEPTH_C);
        out_valid  = nonempty_s && (credit_r[head_s.port_num] != credit_t'(0));
        if (nonempty_s) begin
            out_info = head_s;
        end else begin
            out_info = '0;
        end
        push_s     = in_valid && in_ready;
        pop_s      = out_valid && out_ready;
        fifo_count = count_s;
        ovf_err    = ovf_r;
    end

    // Per-port credit update: pop and return on the same port cancel out.
    always_comb begin
        ovf_hit_s = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            credit_avail[p] = (credit_r[p] != credit_t'(0));
            case ({credit_ret[p], pop_s && (head_s.port_num == PORT_W'(p))})
                2'b01: credit_nxt_s[p] = credit_r[p] - credit_t'(1);
                2'b10: begin
                    if (credit_r[p] == CREDIT_MAX) begin
                        credit_nxt_s[p] = credit_r[p];
                        ovf_hit_s       = 1'b1;
                    end else begin
                        credit_nxt_s[p] = credit_r[p] + credit_t'(1);
                    end
                end
                default: credit_nxt_s[p] = credit_r[p];
            endcase
        end
    end

    // Credit counters, sticky overflow flag and post-reset ready enable.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                credit_r[p] <= CREDIT_MAX;
            end
            ovf_r    <= 1'b0;
            rdy_en_r <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                credit_r[p] <= credit_nxt_s[p];
            end
            ovf_r    <= ovf_r | ovf_hit_s;
            rdy_en_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_port_info_dispatch.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized phase, all compared against a queue-based reference model.
module tb_port_info_dispatch;
    import port_info_pkg::*;

    localparam int DEPTH   = 4;
    localparam int CREDITS = 2;

    logic        clk = 1'b0;
    logic        res;
    logic        in_valid, in_ready, out_valid, out_ready, ovf_err;
    info_t       in_info, out_info;
    logic [15:0] credit_ret, credit_avail;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of destination ports and one credit per port.
    int q[$];
    int cred[16];
    bit m_ovf;
    bit m_en;

    typedef struct {
        logic        iv;
        logic [3:0]  inf;
        logic        ordy;
        logic [15:0] ret;
        logic        ev;
        logic [3:0]  einf;
        logic [2:0]  ecnt;
        logic [15:0] eav;
        logic        erdy;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    port_info_dispatch #(.DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
        .clk          (clk),
        .res          (res),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_info      (in_info),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_info     (out_info),
        .credit_ret   (credit_ret),
        .credit_avail (credit_avail),
        .fifo_count   (fifo_count),
        .ovf_err      (ovf_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int p = 0; p < 16; p++) cred[p] = CREDITS;
        m_ovf = 1'b0;
        m_en  = 1'b0;
    endtask

    task automatic check_model();
        logic [15:0] av;
        logic        v;
        int          hi;
        for (int p = 0; p < 16; p++) av[p] = (cred[p] != 0);
        v  = (q.size() > 0) && (cred[q[0]] > 0);
        hi = (q.size() > 0) ? q[0] : 0;
        chk("m_count", 32'(fifo_count), 32'(q.size()));
        chk("m_valid", 32'(out_valid), 32'(v));
        chk("m_info", 32'(out_info.port_num), 32'(hi));
        chk("m_avail", 32'(credit_avail), 32'(av));
        chk("m_ready", 32'(in_ready), 32'(m_en && (q.size() < DEPTH)));
        chk("m_ovf", 32'(ovf_err), 32'(m_ovf));
    endtask

    // Drive one cycle of inputs, advance the model, clock, then compare.
    task automatic cyc(input logic iv, input logic [3:0] inf, input logic ordy, input logic [15:0] ret);
        bit pop, push;
        int head;
        in_valid   = iv;
        in_info    = inf;
        out_ready  = ordy;
        credit_ret = ret;
        pop  = (q.size() > 0) && (cred[q[0]] > 0) && ordy;
        push = iv && m_en && (q.size() < DEPTH);
        head = pop ? q[0] : -1;
        for (int p = 0; p < 16; p++) begin
            if (p == head && !ret[p]) cred[p]--;
            else if (p != head && ret[p]) begin
                if (cred[p] == CREDITS) m_ovf = 1'b1;
                else cred[p]++;
            end
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back(int'(inf));
        m_en = 1'b1;
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        res = 1'b0;
        in_valid = 1'b0; in_info = '0; out_ready = 1'b0; credit_ret = 16'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_avail", 32'(credit_avail), 32'hFFFF);
        res = 1'b1;
        cyc(1'b0, 4'd0, 1'b0, 16'h0);
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_count", 32'(fifo_count), 32'd0);
        chk("idle_ovf", 32'(ovf_err), 32'd0);

        // Port 3 credit exhaustion, then FIFO fill and in-order drain.
        tbl.push_back('{1'b1, 4'd3, 1'b1, 16'h0000, 1'b1, 4'd3, 3'd1, 16'hFFFF, 1'b1});
        tbl.push_back('{1'b1, 4'd3, 1'b1, 16'h0000, 1'b1, 4'd3, 3'd1, 16'hFFFF, 1'b1});
        tbl.push_back('{1'b1, 4'd3, 1'b1, 16'h0000, 1'b0, 4'd3, 3'd1, 16'hFFF7, 1'b1});
        tbl.push_back('{1'b0, 4'd0, 1'b1, 16'h0008, 1'b1, 4'd3, 3'd1, 16'hFFFF, 1'b1});
        tbl.push_back('{1'b0, 4'd0, 1'b1, 16'h0000, 1'b0, 4'd0, 3'd0, 16'hFFF7, 1'b1});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 16'h0008, 1'b0, 4'd0, 3'd0, 16'hFFFF, 1'b1});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 16'h0008, 1'b0, 4'd0, 3'd0, 16'hFFFF, 1'b1});
        tbl.push_back('{1'b1, 4'd1, 1'b0, 16'h0000, 1'b1, 4'd1, 3'd1, 16'hFFFF, 1'b1});
        tbl.push_back('{1'b1, 4'd2, 1'b0, 16'h0000, 1'b1, 4'd1, 3'd2, 16'hFFFF, 1'b1});
        tbl.push_back('{1'b1, 4'd5, 1'b0, 16'h0000, 1'b1, 4'd1, 3'd3, 16'hFFFF, 1'b1});
        tbl.push_back('{1'b1, 4'd7, 1'b0, 16'h0000, 1'b1, 4'd1, 3'd4, 16'hFFFF, 1'b0});
        tbl.push_back('{1'b1, 4'd9, 1'b0, 16'h0000, 1'b1, 4'd1, 3'd4, 16'hFFFF, 1'b0});
        tbl.push_back('{1'b0, 4'd0, 1'b1, 16'h0000, 1'b1, 4'd2, 3'd3, 16'hFFFF, 1'b1});
        tbl.push_back('{1'b0, 4'd0, 1'b1, 16'h0000, 1'b1, 4'd5, 3'd2, 16'hFFFF, 1'b1});
        tbl.push_back('{1'b0, 4'd0, 1'b1, 16'h0000, 1'b1, 4'd7, 3'd1, 16'hFFFF, 1'b1});
        tbl.push_back('{1'b0, 4'd0, 1'b1, 16'h0000, 1'b0, 4'd0, 3'd0, 16'hFFFF, 1'b1});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 16'h00A6, 1'b0, 4'd0, 3'd0, 16'hFFFF, 1'b1});
        foreach (tbl[i]) begin
            cyc(tbl[i].iv, tbl[i].inf, tbl[i].ordy, tbl[i].ret);
            chk("tbl_valid", 32'(out_valid), 32'(tbl[i].ev));
            chk("tbl_info", 32'(out_info.port_num), 32'(tbl[i].einf));
            chk("tbl_count", 32'(fifo_count), 32'(tbl[i].ecnt));
            chk("tbl_avail", 32'(credit_avail), 32'(tbl[i].eav));
            chk("tbl_ready", 32'(in_ready), 32'(tbl[i].erdy));
        end

        // Head-of-line blocking behind a starved port 4.
        cyc(1'b1, 4'd4, 1'b1, 16'h0);
        cyc(1'b1, 4'd4, 1'b1, 16'h0);
        cyc(1'b0, 4'd0, 1'b1, 16'h0);
        cyc(1'b1, 4'd4, 1'b1, 16'h0);
        cyc(1'b1, 4'd6, 1'b1, 16'h0);
        cyc(1'b0, 4'd0, 1'b1, 16'h0);
        chk("hol_valid", 32'(out_valid), 32'd0);
        chk("hol_info", 32'(out_info.port_num), 32'd4);
        chk("hol_count", 32'(fifo_count), 32'd2);
        cyc(1'b0, 4'd0, 1'b1, 16'h0010);
        chk("hol_rel_valid", 32'(out_valid), 32'd1);
        chk("hol_rel_info", 32'(out_info.port_num), 32'd4);
        cyc(1'b0, 4'd0, 1'b1, 16'h0);
        chk("hol_next_info", 32'(out_info.port_num), 32'd6);
        chk("hol_next_valid", 32'(out_valid), 32'd1);
        cyc(1'b0, 4'd0, 1'b1, 16'h0);
        chk("hol_empty", 32'(fifo_count), 32'd0);
        cyc(1'b0, 4'd0, 1'b0, 16'h0010);
        cyc(1'b0, 4'd0, 1'b0, 16'h0010);

        // Pop and return on port 9 in the same cycle at full credit.
        cyc(1'b1, 4'd9, 1'b1, 16'h0);
        cyc(1'b0, 4'd0, 1'b1, 16'h0200);
        chk("netzero_ovf", 32'(ovf_err), 32'd0);
        cyc(1'b1, 4'd9, 1'b0, 16'h0);
        cyc(1'b1, 4'd9, 1'b0, 16'h0);
        cyc(1'b0, 4'd0, 1'b1, 16'h0);
        chk("netzero_avail9_a", 32'(credit_avail[9]), 32'd1);
        cyc(1'b0, 4'd0, 1'b1, 16'h0);
        chk("netzero_avail9_b", 32'(credit_avail[9]), 32'd0);
        cyc(1'b0, 4'd0, 1'b0, 16'h0200);
        cyc(1'b0, 4'd0, 1'b0, 16'h0200);

        // Return on port 9 with the counter already full.
        cyc(1'b0, 4'd0, 1'b0, 16'h0200);
        chk("ovf_set", 32'(ovf_err), 32'd1);
        cyc(1'b0, 4'd0, 1'b0, 16'h0);
        chk("ovf_sticky", 32'(ovf_err), 32'd1);
        chk("ovf_avail", 32'(credit_avail), 32'hFFFF);

        // Reset with three buffered records and port 0 starved.
        repeat (5) cyc(1'b1, 4'd0, 1'b1, 16'h0);
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        chk("pre_rst_avail0", 32'(credit_avail[0]), 32'd0);
        #1;
        res = 1'b0;
        #1;
        model_reset();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_avail", 32'(credit_avail), 32'hFFFF);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_ovf", 32'(ovf_err), 32'd0);
        @(posedge clk);
        #1;
        res = 1'b1;
        cyc(1'b0, 4'd0, 1'b0, 16'h0);
        cyc(1'b1, 4'd0, 1'b0, 16'h0);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_info", 32'(out_info.port_num), 32'd0);
        cyc(1'b0, 4'd0, 1'b1, 16'h0);
        cyc(1'b0, 4'd0, 1'b0, 16'h0001);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 3) != 0),
                16'($urandom & $urandom & $urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
